uart_rx_fifo: RTL and testbench

//  UART receiver with a programmable bit-period divisor and a 3-sample majority vote at
//  mid-bit. Detects parity, framing and break errors per frame and buffers frames in an RX FIFO.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM states, FIFO entry layout and latched frame config.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    typedef struct packed {
        logic [1:0] data_bit_num;
        logic       stop_bit_num;
        logic       parity_en;
        logic       parity_type;
    } rx_cfg_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // Index of the last data bit: 00..11 selects 5..8 data bits.
    function automatic logic [2:0] last_data_idx(input logic [1:0] data_bit_num);
        return 3'd4 + {1'b0, data_bit_num};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with fill count and registered full/empty flags.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // A push while full is accepted only when a pop frees the head slot in the same cycle.
    assign do_push    = push && (!full || pop);
    assign do_pop     = pop && !empty;
    assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign rdata      = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage has no reset; contents are only ever observed behind a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, programmable bit timer, 3-sample majority vote,
// frame FSM with parity/framing/break detection, RX FIFO, overrun flag and rts_n flow control.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_THRESH = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    data_bit_num,
    input  logic                          stop_bit_num,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic                          rd_en,
    input  logic                          clr_overrun,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          break_det,
    output logic                          rx_done,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rts_n
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] RTS_LVL = CNT_W'(RTS_THRESH);

    rx_state_e        state, state_next;
    rx_cfg_t          cfg;
    logic [1:0]       sync_q;
    logic             rxs, rxs_d, start_edge;
    logic [DIV_W-1:0] tcnt, half;
    logic             timer_run, tick_last, vote_now;
    logic             s0, s1, bit_val;
    logic [7:0]       data_q;
    logic [2:0]       bit_idx;
    logic             stop_idx, last_stop;
    logic             ferr_q, perr_q, par_sample;
    logic             ferr_next, frame_brk;
    logic             cfg_load, shift_en, bit_adv, par_en, stop_en, stop_adv, push_dec;
    logic             push_req;
    rx_entry_t        entry_q, head;
    logic [ENTRY_W-1:0] head_raw;
    logic             fifo_full, fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx};
            rxs_d  <= sync_q[1];
        end
    end

    assign rxs        = sync_q[1];
    assign start_edge = rxs_d & ~rxs;

    // Bit timer idles at 0 so a detected start edge begins the start bit at count 0.
    assign half      = baud_div >> 1;
    assign timer_run = (state != IDLE) && (state != BRK_WAIT);
    assign tick_last = (tcnt == baud_div - DIV_W'(1));
    assign vote_now  = timer_run && (tcnt == half + DIV_W'(1));
    assign bit_val   = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
            s0   <= 1'b1;
            s1   <= 1'b1;
        end else begin
            if (!timer_run || tick_last) tcnt <= '0;
            else                         tcnt <= tcnt + DIV_W'(1);
            if (timer_run && tcnt == half - DIV_W'(1)) s0 <= rxs;
            if (timer_run && tcnt == half)             s1 <= rxs;
        end
    end

    assign last_stop = (stop_idx == cfg.stop_bit_num);
    assign ferr_next = ferr_q | ~bit_val;
    assign frame_brk = ferr_next && (data_q == 8'h00) && (!cfg.parity_en || !par_sample);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every always_comb assigns its outputs a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_edge) state_next = START;
            START:    if (vote_now && bit_val) state_next = IDLE;
                      else if (tick_last)      state_next = DATA;
            DATA:     if (tick_last && bit_idx == last_data_idx(cfg.data_bit_num))
                          state_next = cfg.parity_en ? PARITY : STOP;
            PARITY:   if (tick_last) state_next = STOP;
            STOP:     if (vote_now && last_stop) state_next = frame_brk ? BRK_WAIT : IDLE;
            BRK_WAIT: if (rxs) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_load = 1'b0;
        shift_en = 1'b0;
        bit_adv  = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        stop_adv = 1'b0;
        push_dec = 1'b0;
        case (state)
            IDLE:   cfg_load = start_edge;
            DATA:   begin
                        shift_en = vote_now;
                        bit_adv  = tick_last;
                    end
            PARITY: par_en = vote_now;
            STOP:   begin
                        stop_en  = vote_now;
                        stop_adv = tick_last;
                        push_dec = vote_now && last_stop;
                    end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg        <= '0;
            data_q     <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            par_sample <= 1'b0;
            push_req   <= 1'b0;
            entry_q    <= '0;
        end else begin
            push_req <= push_dec;
            if (cfg_load) begin
                cfg        <= rx_cfg_t'{data_bit_num, stop_bit_num, parity_en, parity_type};
                data_q     <= '0;
                bit_idx    <= '0;
                stop_idx   <= 1'b0;
                ferr_q     <= 1'b0;
                perr_q     <= 1'b0;
                par_sample <= 1'b0;
            end
            if (shift_en) data_q[bit_idx] <= bit_val;
            if (bit_adv)  bit_idx <= bit_idx + 3'd1;
            if (par_en) begin
                perr_q     <= (^data_q ^ bit_val) ^ cfg.parity_type;
                par_sample <= bit_val;
            end
            if (stop_en)  ferr_q   <= ferr_next;
            if (stop_adv) stop_idx <= ~stop_idx;
            if (push_dec) entry_q  <= rx_entry_t'{frame_brk, ferr_next, perr_q, data_q};
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (rd_en),
        .wdata   (entry_q),
        .rdata   (head_raw),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A set wins over a simultaneous clear so a drop is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
            rts_n   <= 1'b1;
        end else begin
            if (push_req && fifo_full && !rd_en) overrun <= 1'b1;
            else if (clr_overrun)                overrun <= 1'b0;
            rts_n <= (fifo_count >= RTS_LVL);
        end
    end

    assign head         = rx_entry_t'(head_raw);
    assign rx_valid     = ~fifo_empty;
    assign rx_data      = rx_valid ? head.data : 8'h00;
    assign parity_error = rx_valid & head.perr;
    assign frame_error  = rx_valid & head.ferr;
    assign break_det    = rx_valid & head.brk;
    assign rx_done      = push_req;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven as 16-clock bits, checks via immediate assertions.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  data_bit_num;
    logic        stop_bit_num;
    logic        parity_en;
    logic        parity_type;
    logic        rd_en;
    logic        clr_overrun;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        parity_error;
    logic        frame_error;
    logic        break_det;
    logic        rx_done;
    logic        overrun;
    logic [4:0]  fifo_count;
    logic        rts_n;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int base;
    int n;

    uart_rx_fifo #(
        .DIV_W      (16),
        .FIFO_DEPTH (16),
        .RTS_THRESH (12)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .baud_div     (baud_div),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .rd_en        (rd_en),
        .clr_overrun  (clr_overrun),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .break_det    (break_det),
        .rx_done      (rx_done),
        .overrun      (overrun),
        .fifo_count   (fifo_count),
        .rts_n        (rts_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        rx = v;
        if (glitch) begin
            repeat (9) @(negedge clk);
            rx = ~v;
            @(negedge clk);
            rx = v;
            repeat (6) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    // Start bit, LSB-first data, optional parity, stop bits, then one idle bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input logic pbit, input int nstop, input int gbit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i], i == gbit);
        if (pen) send_bit(pbit, 1'b0);
        for (int i = 0; i < nstop; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] dbn, input logic sbn, input logic pen, input logic ptype);
        data_bit_num = dbn;
        stop_bit_num = sbn;
        parity_en    = pen;
        parity_type  = ptype;
    endtask

    initial begin
        reset_n     = 1'b0;
        rx          = 1'b1;
        baud_div    = 16'd16;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_fifo_count", 32'(fifo_count), 32'h0);
        check("reset_rts_n", 32'(rts_n), 32'h1);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rts_after_release", 32'(rts_n), 32'h0);

        // 1: 8N1 0xA5
        base = done_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, -1);
        check("t1_count", 32'(fifo_count), 32'h1);
        check("t1_valid", 32'(rx_valid), 32'h1);
        check("t1_data", 32'(rx_data), 32'hA5);
        check("t1_flags", {29'h0, parity_error, frame_error, break_det}, 32'h0);
        check("t1_done_pulses", 32'(done_cnt - base), 32'h1);
        pop();
        check("t1_valid_after_pop", 32'(rx_valid), 32'h0);

        // 2: 7E2 0x35 (four ones -> even parity bit 0), then 5O1 0x1F (five ones -> odd parity bit 0)
        set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 2, -1);
        check("t2_bad_par_perr", 32'(parity_error), 32'h1);
        check("t2_bad_par_data", 32'(rx_data), 32'h35);
        check("t2_bad_par_ferr", 32'(frame_error), 32'h0);
        pop();
        send_frame(8'h35, 7, 1'b1, 1'b0, 2, -1);
        check("t2_good_par_perr", 32'(parity_error), 32'h0);
        check("t2_good_par_data", 32'(rx_data), 32'h35);
        pop();
        set_cfg(2'b00, 1'b0, 1'b1, 1'b1);
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1, -1);
        check("t2_5o1_data", 32'(rx_data), 32'h1F);
        check("t2_5o1_perr", 32'(parity_error), 32'h0);
        pop();

        // 3: short start glitch, then a mid-bit data glitch
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        base = done_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_glitch_count", 32'(fifo_count), 32'h0);
        check("t3_glitch_done", 32'(done_cnt - base), 32'h0);
        check("t3_glitch_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 3);
        check("t3_vote_data", 32'(rx_data), 32'h5A);
        check("t3_vote_count", 32'(fifo_count), 32'h1);
        pop();

        // 4: break, 20 bit times low
        base = done_cnt;
        rx = 1'b0;
        repeat (320) @(negedge clk);
        check("t4_brk_count", 32'(fifo_count), 32'h1);
        check("t4_brk_det", 32'(break_det), 32'h1);
        check("t4_brk_ferr", 32'(frame_error), 32'h1);
        check("t4_brk_data", 32'(rx_data), 32'h0);
        check("t4_brk_done", 32'(done_cnt - base), 32'h1);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        check("t4_after_rise_count", 32'(fifo_count), 32'h1);
        pop();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, -1);
        check("t4_next_data", 32'(rx_data), 32'h3C);
        check("t4_next_brk", 32'(break_det), 32'h0);
        pop();

        // 5: fill past depth
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 8, 1'b0, 1'b0, 1, -1);
            if (i == 11) check("t5_rts_at_11", 32'(rts_n), 32'h0);
            if (i == 12) check("t5_rts_at_12", 32'(rts_n), 32'h1);
        end
        check("t5_full_count", 32'(fifo_count), 32'd16);
        check("t5_overrun_set", 32'(overrun), 32'h1);
        check("t5_head", 32'(rx_data), 32'h01);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        check("t5_overrun_clr", 32'(overrun), 32'h0);
        fork
            send_frame(8'h55, 8, 1'b0, 1'b0, 1, -1);
            begin
                n = 0;
                while (rx_done !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_done_seen", 32'(rx_done), 32'h1);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        check("t5_push_pop_overrun", 32'(overrun), 32'h0);
        check("t5_push_pop_count", 32'(fifo_count), 32'd16);
        for (int k = 2; k <= 16; k++) begin
            check("t5_drain", 32'(rx_data), 32'(k));
            pop();
        end
        check("t5_tail", 32'(rx_data), 32'h55);
        pop();
        check("t5_empty", 32'(rx_valid), 32'h0);

        // 6: reset during data bit 4
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, -1);
        check("t6_pre_count", 32'(fifo_count), 32'h1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_valid", 32'(rx_valid), 32'h0);
        check("t6_rst_count", 32'(fifo_count), 32'h0);
        check("t6_rst_rts", 32'(rts_n), 32'h1);
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rts_release", 32'(rts_n), 32'h0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1, -1);
        check("t6_after_data", 32'(rx_data), 32'hC3);
        check("t6_after_count", 32'(fifo_count), 32'h1);
        check("t6_after_flags", {29'h0, parity_error, frame_error, break_det}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
